// File: rtl/ring_data_buffer_pkg.sv
// usb_buffer_pkg: shared size-code type and byte-count helper for the ring buffer
// Contents:
//   size_code_t  2-bit transfer size code (none / 1 B / 2 B / 4 B)
//   size_bytes   maps a size code to its byte count 0/1/2/4
package usb_buffer_pkg;
   typedef enum logic [1:0] {SZ_NONE, SZ_1, SZ_2, SZ_4} size_code_t;
   function automatic logic [2:0] size_bytes(size_code_t c);
      return (c == SZ_4) ? 3'd4 : (c == SZ_2) ? 3'd2 : (c == SZ_1) ? 3'd1 : 3'd0;
   endfunction
endpackage

// File: rtl/ring_data_buffer_ptr.sv
// buffer_ptr: wrap-bit pointer for the ring buffer with sync clear and advance-by-n
// Ports:
//   clk, n_rst  clock, async active-low reset
//   clr         sync return to zero (dominates advance)
//   adv         bytes to advance this cycle (0..4)
//   ptr         pointer; MSB is the wrap bit, low bits index storage
module buffer_ptr
   import usb_buffer_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       clr,
   input  logic [2:0]                 adv,
   output logic [$clog2(DEPTH):0]     ptr
);
   localparam int PW = $clog2(DEPTH) + 1;
   logic [PW-1:0] ptr_q, ptr_d;
   always_comb ptr_d = clr ? '0 : ptr_q + PW'(adv);
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   assign ptr = ptr_q;
endmodule

// File: rtl/ring_data_buffer.sv
// ring_data_buffer: circular byte buffer between a USB byte stream and an AHB 1/2/4-byte port
// Ports:
//   clk, n_rst                    clock, async active-low reset
//   flush, clear                  sync discard of all contents and error flags
//   buffer_occ, full, empty       occupancy and derived status
//   almost_full                   occupancy >= AF_LEVEL
//   err_overflow/underflow/collision  sticky error flags
//   store_rx_data, rx_data_in     USB side 1-byte write
//   get_rx_data, rx_data_out      AHB side sized read, oldest byte in lane 0
//   store_tx_data, tx_data_in     AHB side sized write, lane 0 first
//   get_tx_data, tx_data_out      USB side 1-byte read
module ring_data_buffer
   import usb_buffer_pkg::*;
#(
   parameter int DEPTH         = 64,
   parameter int AF_LEVEL      = DEPTH - 4,
   parameter bit ZERO_ON_CLEAR = 1'b1
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     flush,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   buffer_occ,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     err_overflow,
   output logic                     err_underflow,
   output logic                     err_collision,
   input  logic                     store_rx_data,
   input  logic [7:0]               rx_data_in,
   input  logic [1:0]               get_rx_data,
   output logic [31:0]              rx_data_out,
   input  logic [1:0]               store_tx_data,
   input  logic [31:0]              tx_data_in,
   input  logic                     get_tx_data,
   output logic [7:0]               tx_data_out
);
   localparam int AW    = $clog2(DEPTH);
   localparam int OCC_W = AW + 1;
   logic [OCC_W-1:0] wr_ptr, rd_ptr, occ, free;
   logic [2:0]       wr_n, rd_n, wr_adv, rd_adv;
   logic             clr, wr_ok, rd_ok, wr_col, rd_col;
   logic [7:0]       wbyte  [4];
   logic [AW-1:0]    wr_idx [4];
   logic [AW-1:0]    rd_idx [4];
   logic [7:0]       mem_q  [DEPTH];
   logic             ovf_q, ovf_d, unf_q, unf_d, col_q, col_d;
   buffer_ptr #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .n_rst(n_rst), .clr(clr), .adv(wr_adv), .ptr(wr_ptr));
   buffer_ptr #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .n_rst(n_rst), .clr(clr), .adv(rd_adv), .ptr(rd_ptr));
   // Wrap-bit pointers make the plain difference the occupancy, including the full case.
   assign occ  = wr_ptr - rd_ptr;
   assign free = OCC_W'(DEPTH) - occ;
   always_comb begin
      clr         = clear | flush;
      wr_col      = store_rx_data && (store_tx_data != 2'b00);
      rd_col      = get_tx_data && (get_rx_data != 2'b00);
      wr_n        = store_rx_data ? 3'd1 : size_bytes(size_code_t'(store_tx_data));
      rd_n        = get_tx_data ? 3'd1 : size_bytes(size_code_t'(get_rx_data));
      // Both checks use start-of-cycle occupancy: no same-cycle bypass either way.
      wr_ok       = !clr && (wr_n != 3'd0) && (OCC_W'(wr_n) <= free);
      rd_ok       = !clr && (rd_n != 3'd0) && (OCC_W'(rd_n) <= occ);
      wr_adv      = wr_ok ? wr_n : 3'd0;
      rd_adv      = rd_ok ? rd_n : 3'd0;
      rx_data_out = '0;
      for (int k = 0; k < 4; k++) begin
         wbyte[k]  = store_rx_data ? ((k == 0) ? rx_data_in : 8'h00) : tx_data_in[8*k +: 8];
         wr_idx[k] = wr_ptr[AW-1:0] + AW'(k);
         rd_idx[k] = rd_ptr[AW-1:0] + AW'(k);
         rx_data_out[8*k +: 8] = (OCC_W'(k) < occ) ? mem_q[rd_idx[k]] : 8'h00;
      end
      tx_data_out = (occ != '0) ? mem_q[rd_ptr[AW-1:0]] : 8'h00;
      ovf_d       = clr ? 1'b0 : ovf_q | ((wr_n != 3'd0) && !wr_ok);
      unf_d       = clr ? 1'b0 : unf_q | ((rd_n != 3'd0) && !rd_ok);
      col_d       = clr ? 1'b0 : col_q | wr_col | rd_col;
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         col_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         col_q <= col_d;
      end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) mem_q <= '{default: 8'h00};
      else if (clr) begin
         if (ZERO_ON_CLEAR) mem_q <= '{default: 8'h00};
      end else if (wr_ok) begin
         for (int k = 0; k < 4; k++)
            if (3'(k) < wr_n) mem_q[wr_idx[k]] <= wbyte[k];
      end
   assign buffer_occ    = occ;
   assign full          = (occ == OCC_W'(DEPTH));
   assign empty         = (occ == '0);
   assign almost_full   = (occ >= OCC_W'(AF_LEVEL));
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;
   assign err_collision = col_q;
endmodule

// File: tb/tb_ring_data_buffer.sv
// tb_ring_data_buffer: directed and random checks of ring_data_buffer against a byte-queue model
module tb_ring_data_buffer;
   localparam int DEPTH = 64;
   localparam int AF    = DEPTH - 4;
   logic        clk = 1'b0, n_rst = 1'b0, flush = 1'b0, clear = 1'b0;
   logic        store_rx_data = 1'b0, get_tx_data = 1'b0;
   logic [7:0]  rx_data_in = '0;
   logic [1:0]  get_rx_data = '0, store_tx_data = '0;
   logic [31:0] tx_data_in = '0;
   logic [6:0]  buffer_occ;
   logic        full, empty, almost_full, err_overflow, err_underflow, err_collision;
   logic [31:0] rx_data_out;
   logic [7:0]  tx_data_out;
   int          n_assert = 0, n_fail = 0;
   byte unsigned q[$];
   bit          m_ovf = 0, m_unf = 0, m_col = 0;

   ring_data_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .n_rst(n_rst), .flush(flush), .clear(clear),
      .buffer_occ(buffer_occ), .full(full), .empty(empty), .almost_full(almost_full),
      .err_overflow(err_overflow), .err_underflow(err_underflow), .err_collision(err_collision),
      .store_rx_data(store_rx_data), .rx_data_in(rx_data_in), .get_rx_data(get_rx_data),
      .rx_data_out(rx_data_out), .store_tx_data(store_tx_data), .tx_data_in(tx_data_in),
      .get_tx_data(get_tx_data), .tx_data_out(tx_data_out));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic int sz(logic [1:0] c);
      return (c == 2'd3) ? 4 : int'(c);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(string tag);
      logic [31:0] erx;
      int          n;
      n   = q.size();
      erx = '0;
      for (int k = 0; k < 4; k++) if (k < n) erx[8*k +: 8] = q[k];
      chk({tag, ":occ"}, 32'(buffer_occ), n);
      chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ":afull"}, 32'(almost_full), 32'(n >= AF));
      chk({tag, ":flags"}, {29'd0, err_overflow, err_underflow, err_collision}, {29'd0, m_ovf, m_unf, m_col});
      chk({tag, ":rx_out"}, rx_data_out, erx);
      chk({tag, ":tx_out"}, 32'(tx_data_out), (n > 0) ? 32'(q[0]) : 32'd0);
   endtask

   // Drive one cycle of requests from a negedge, update the model, then check at the next negedge.
   task automatic step(input logic srx, input logic [7:0] rxd, input logic [1:0] stx, input logic [31:0] txd,
                       input logic gtx, input logic [1:0] grx, input logic clr, input logic fl, input string tag);
      int occ0, wn, rn;
      store_rx_data = srx; rx_data_in = rxd; store_tx_data = stx; tx_data_in = txd;
      get_tx_data = gtx; get_rx_data = grx; clear = clr; flush = fl;
      @(posedge clk);
      occ0 = q.size();
      wn   = srx ? 1 : sz(stx);
      rn   = gtx ? 1 : sz(grx);
      if (clr || fl) begin
         q.delete();
         m_ovf = 0; m_unf = 0; m_col = 0;
      end else begin
         if ((srx && stx != 0) || (gtx && grx != 0)) m_col = 1;
         if (rn > 0) begin
            if (rn <= occ0) repeat (rn) void'(q.pop_front());
            else m_unf = 1;
         end
         if (wn > 0) begin
            if (wn <= DEPTH - occ0) begin
               if (srx) q.push_back(rxd);
               else for (int k = 0; k < wn; k++) q.push_back(txd[8*k +: 8]);
            end else m_ovf = 1;
         end
      end
      @(negedge clk);
      store_rx_data = 0; store_tx_data = 0; get_tx_data = 0; get_rx_data = 0; clear = 0; flush = 0;
      chk_all(tag);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_all("reset");
      n_rst = 1'b1;
      @(negedge clk);
      // 4-byte AHB write then 4-byte AHB read
      step(0, 0, 2'd3, 32'hDDCCBBAA, 0, 0, 0, 0, "tx4");
      chk("tx4_word", rx_data_out, 32'hDDCCBBAA);
      step(0, 0, 0, 0, 0, 2'd3, 0, 0, "rd4");
      chk("rd4_empty", 32'(buffer_occ), 32'd0);
      // fill to 62, overflow on 4, then exact fill with 2
      for (int i = 0; i < 62; i++) step(1, 8'($urandom), 0, 0, 0, 0, 0, 0, "fill");
      step(0, 0, 2'd3, $urandom, 0, 0, 0, 0, "ovf4");
      chk("ovf4_flag", 32'(err_overflow), 32'd1);
      chk("ovf4_occ", 32'(buffer_occ), 32'd62);
      step(0, 0, 2'd2, $urandom, 0, 0, 0, 0, "fill2");
      chk("fill2_full", 32'(full), 32'd1);
      step(0, 0, 0, 0, 0, 0, 1, 0, "clear1");
      // wrap-around: 60 in, 60 out, then 8 across the 63->0 boundary
      for (int i = 0; i < 15; i++) step(0, 0, 2'd3, $urandom, 0, 0, 0, 0, "wrap_w");
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 2'd3, 0, 0, "wrap_r");
      step(0, 0, 2'd3, 32'h44332211, 0, 0, 0, 0, "wrap_w8a");
      step(0, 0, 2'd3, 32'h88776655, 0, 0, 0, 0, "wrap_w8b");
      chk("wrap_lanes", rx_data_out, 32'h44332211);
      for (int i = 0; i < 8; i++) begin
         chk("wrap_order", 32'(tx_data_out), 32'(i + 1) * 32'h11);
         step(0, 0, 0, 0, 1, 0, 0, 0, "wrap_pop");
      end
      // concurrent write and read at occupancy 5
      for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0, 0, 0, 0, 0, "pre5");
      for (int i = 0; i < 4; i++) begin
         step(1, 8'(8'h40 + i), 0, 0, 1, 0, 0, 0, "rw5");
         chk("rw5_occ", 32'(buffer_occ), 32'd5);
      end
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0, 0, "drain5");
      // underflow on empty, cleared by flush
      step(0, 0, 0, 0, 0, 2'd2, 0, 0, "unf");
      chk("unf_flag", 32'(err_underflow), 32'd1);
      chk("unf_rx", rx_data_out, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 1, "flush1");
      chk("flush_unf", 32'(err_underflow), 32'd0);
      // write collision: rx byte wins
      step(1, 8'h5A, 2'd3, 32'hCAFEF00D, 0, 0, 0, 0, "wcol");
      chk("wcol_data", rx_data_out, 32'h0000005A);
      chk("wcol_flag", 32'(err_collision), 32'd1);
      step(0, 0, 2'd2, 32'h0000BEEF, 1, 2'd1, 0, 0, "rcol");
      // asynchronous reset in the middle of a cycle with a write pending
      store_tx_data = 2'd3; tx_data_in = 32'h12345678;
      #2 n_rst = 1'b0;
      #1;
      q.delete(); m_ovf = 0; m_unf = 0; m_col = 0;
      chk_all("async_rst");
      @(negedge clk);
      store_tx_data = 0;
      n_rst = 1'b1;
      chk_all("post_rst");
      // random traffic with alternating write-heavy/read-heavy phases
      for (int i = 0; i < 3000; i++) begin
         bit wh;
         logic srx, gtx, clr, fl;
         logic [1:0] stx, grx;
         wh  = ((i / 150) % 2) == 0;
         srx = $urandom_range(0, 3) == 0;
         stx = ($urandom_range(0, 9) < (wh ? 6 : 2)) ? 2'($urandom_range(1, 3)) : 2'd0;
         gtx = $urandom_range(0, 5) == 0;
         grx = ($urandom_range(0, 9) < (wh ? 2 : 6)) ? 2'($urandom_range(1, 3)) : 2'd0;
         clr = $urandom_range(0, 299) == 0;
         fl  = $urandom_range(0, 299) == 0;
         step(srx, 8'($urandom), stx, $urandom, gtx, grx, clr, fl, "rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
